// File: rtl/jar_sram_burst.sv
// jar_sram_burst
//   Pin-limited SRAM: address and data travel over a narrow shared bus in
//   BW-bit beats, low beat first. Writes commit automatically on the last
//   beat of a word; reads stream a word back as NB beats. The word address
//   auto-increments (wrapping at DEPTH) after every committed write and
//   every completed read.
//
//   Handshake: there is no ready signal. A command is acted on only when the
//   FSM is IDLE (busy=0). Any non-NOP command sampled while busy is dropped
//   and sets the sticky err flag. Read beats are presented with out_valid=1
//   for exactly one cycle each, and bus_out is 0 whenever out_valid=0.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset (memory array is kept)
//   bus_in     in   BW  address/data beat
//   cmd        in   2   00 NOP, 01 WRITE beat, 10 READ word, 11 SET_ADDR beat
//   bus_out    out  BW  read data beat
//   out_valid  out  1   bus_out carries a read beat
//   busy       out  1   read burst in progress
//   err        out  1   sticky collision flag
//   addr_out   out  AW  current word address
module jar_sram_burst #(
  parameter int DW    = 8,
  parameter int BW    = 4,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int NB   = DW / BW,
  localparam int AB   = (AW + BW - 1) / BW,
  localparam int ABW  = AB * BW,
  localparam int CW   = $clog2(NB + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] bus_in,
  input  logic [1:0]    cmd,
  output logic [BW-1:0] bus_out,
  output logic          out_valid,
  output logic          busy,
  output logic          err,
  output logic [AW-1:0] addr_out
);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_ADDR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic [ABW-1:0]  r_asr;
  logic [DW-1:0]   r_dsr;
  logic [CW-1:0]   r_wcnt;
  logic [CW-1:0]   r_rcnt;
  logic [BW-1:0]   r_bus_out;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_err;
  logic [DW-1:0]   r_mem [DEPTH];

  logic [DW-1:0]   w_wdata;
  logic [ABW-1:0]  w_anext;
  logic [DW-1:0]   w_rword;
  logic            w_last_wbeat;
  logic            w_commit;

  // Incoming beat enters at the top, so after NB (or AB) beats the first
  // beat has reached the bottom: low beat first on the wire.
  generate
    if (NB > 1) begin : g_dsr_multi
      assign w_wdata = {bus_in, r_dsr[DW-1:BW]};
    end else begin : g_dsr_single
      assign w_wdata = bus_in;
    end
    if (AB > 1) begin : g_asr_multi
      assign w_anext = {bus_in, r_asr[ABW-1:BW]};
    end else begin : g_asr_single
      assign w_anext = bus_in;
    end
  endgenerate

  assign w_rword      = r_mem[r_addr];
  assign w_last_wbeat = (r_wcnt == CW'(NB - 1));
  // Gated by rst_n so a write cannot slip into the array while reset is held.
  assign w_commit     = rst_n && (r_state == S_IDLE) && (cmd == CMD_WRITE) && w_last_wbeat;

  // Memory array: deliberately not reset, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[r_addr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_asr       <= '0;
      r_dsr       <= '0;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_bus_out   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Collision detection: anything but NOP while a burst is running.
      if (r_state != S_IDLE && cmd != CMD_NOP) r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          // The last read beat (if any) was shown for one cycle; drop it now.
          r_out_valid <= 1'b0;
          r_bus_out   <= '0;
          case (cmd)
            CMD_ADDR: begin
              r_asr  <= w_anext;
              r_addr <= w_anext[AW-1:0];
              r_wcnt <= '0;
            end
            CMD_WRITE: begin
              if (w_last_wbeat) begin
                r_addr <= r_addr + AW'(1);
                r_wcnt <= '0;
              end else begin
                r_wcnt <= r_wcnt + CW'(1);
              end
              r_dsr <= w_wdata;
            end
            CMD_READ: begin
              r_wcnt  <= '0;
              r_busy  <= 1'b1;
              r_state <= S_FETCH;
            end
            default: ;
          endcase
        end
        S_FETCH: begin
          // First beat goes straight out; the rest wait in the shift reg.
          r_bus_out   <= w_rword[BW-1:0];
          r_dsr       <= w_rword >> BW;
          r_out_valid <= 1'b1;
          if (NB == 1) begin
            r_addr  <= r_addr + AW'(1);
            r_busy  <= 1'b0;
            r_rcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_rcnt  <= CW'(1);
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bus_out   <= r_dsr[BW-1:0];
          r_dsr       <= r_dsr >> BW;
          r_out_valid <= 1'b1;
          // Returning to IDLE on the last beat lets the next command be
          // sampled while that beat is still on the bus.
          if (r_rcnt == CW'(NB - 1)) begin
            r_addr  <= r_addr + AW'(1);
            r_busy  <= 1'b0;
            r_rcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_rcnt <= r_rcnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_out   = r_bus_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign err       = r_err;
  assign addr_out  = r_addr;

endmodule

// File: tb/tb_jar_sram_burst.sv
// Bench for jar_sram_burst with default parameters (DW=8, BW=4, DEPTH=16).
// Driver tasks change inputs on the falling edge; the monitor samples 1ns
// after each rising edge and pops expected read beats from exp_q.
module tb_jar_sram_burst;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] RD  = 2'b10;
  localparam logic [1:0] SA  = 2'b11;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] bus_in;
  logic [1:0]    cmd;
  logic [BW-1:0] bus_out;
  logic          out_valid;
  logic          busy;
  logic          err;
  logic [AW-1:0] addr_out;

  logic [BW-1:0] exp_q[$];
  int n_checks;
  int n_fail;
  bit mon_en;

  jar_sram_burst #(.DW(DW), .BW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .cmd(cmd),
    .bus_out(bus_out), .out_valid(out_valid), .busy(busy),
    .err(err), .addr_out(addr_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: called at a falling edge, return at the next falling edge
  // after the command has been sampled, with cmd back at NOP.
  task automatic issue(input logic [1:0] c, input logic [BW-1:0] d);
    cmd = c;
    bus_in = d;
    @(negedge clk);
    cmd = NOP;
    bus_in = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(NOP, '0);
  endtask

  // Issue a READ and queue its expected beats, then wait out the burst.
  task automatic read_word(input logic [DW-1:0] word);
    exp_q.push_back(word[3:0]);
    exp_q.push_back(word[7:4]);
    issue(RD, '0);
    idle(2);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n) begin
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %0h with nothing expected", bus_out);
        end else begin
          logic [BW-1:0] e;
          e = exp_q.pop_front();
          if (bus_out !== e) begin
            n_fail++;
            $display("FAIL read_beat: got %0h expected %0h", bus_out, e);
          end
        end
      end else if (bus_out !== '0) begin
        n_checks++;
        n_fail++;
        $display("FAIL idle_bus: got %0h expected 0 (out_valid=%b)", bus_out, out_valid);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    mon_en = 1'b0;
    cmd = NOP;
    bus_in = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bus_out", 8'(bus_out), 8'h0);
    check("rst_out_valid", 8'(out_valid), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_err", 8'(err), 8'h0);
    check("rst_addr", 8'(addr_out), 8'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // 1. basic write then read back
    issue(SA, 4'h3); issue(WR, 4'h5); issue(WR, 4'hA);
    check("t1_addr_after_write", 8'(addr_out), 8'h4);
    issue(SA, 4'h3);
    check("t1_set_addr", 8'(addr_out), 8'h3);
    read_word(8'hA5);
    check("t1_addr_after_read", 8'(addr_out), 8'h4);

    // 2. wrap-around on commit and on read
    issue(SA, 4'hF); issue(WR, 4'h1); issue(WR, 4'h1); issue(WR, 4'h2); issue(WR, 4'h2);
    check("t2_addr_after_wrap_write", 8'(addr_out), 8'h1);
    issue(SA, 4'hF);
    read_word(8'h11);
    check("t2_addr_after_wrap_read", 8'(addr_out), 8'h0);
    read_word(8'h22);
    check("t2_addr_after_read0", 8'(addr_out), 8'h1);

    // 3. partial write word discarded by SET_ADDR
    issue(WR, 4'h7); issue(SA, 4'h2); issue(WR, 4'h1); issue(WR, 4'h2);
    check("t3_addr", 8'(addr_out), 8'h3);
    issue(SA, 4'h2);
    read_word(8'h21);

    // 4. collision: WRITE one edge after READ
    issue(SA, 4'h3);
    exp_q.push_back(4'h5);
    exp_q.push_back(4'hA);
    issue(RD, '0);
    check("t4_busy", 8'(busy), 8'h1);
    issue(WR, 4'hF);
    issue(NOP, '0);
    check("t4_err", 8'(err), 8'h1);
    check("t4_addr", 8'(addr_out), 8'h4);
    check("t4_busy_done", 8'(busy), 8'h0);
    issue(SA, 4'h3);
    read_word(8'hA5);
    check("t4_err_sticky", 8'(err), 8'h1);

    // 5. reset between read beats
    issue(SA, 4'h3);
    exp_q.push_back(4'h5);
    issue(RD, '0);
    issue(NOP, '0);
    rst_n = 1'b0;
    #1;
    check("t5_bus_out", 8'(bus_out), 8'h0);
    check("t5_out_valid", 8'(out_valid), 8'h0);
    check("t5_busy", 8'(busy), 8'h0);
    check("t5_addr", 8'(addr_out), 8'h0);
    check("t5_err", 8'(err), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(SA, 4'h3);
    read_word(8'hA5);
    issue(SA, 4'hF);
    read_word(8'h11);

    // 6. back-to-back reads from consecutive addresses
    issue(SA, 4'h6); issue(WR, 4'h3); issue(WR, 4'h4); issue(WR, 4'h5); issue(WR, 4'h6);
    issue(SA, 4'h6);
    read_word(8'h43);
    read_word(8'h65);
    check("t6_err", 8'(err), 8'h0);
    check("t6_addr", 8'(addr_out), 8'h8);

    // Drain scoreboard with a bound
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats never appeared, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
